spi_reg_master: RTL
===================

Name: spi_reg_master

Overview:
- SPI controller (initiator) that issues single-register read and write frames to the team's SPI register peripheral.
- Mode: CPOL=0, CPHA=1, MSB first.
- Takes requests over a valid/ready port, generates sclk, cs, mosi, captures miso, and returns read data with a one-cycle response strobe.
- Sits between on-chip control logic and the chip-level SPI pins; the only clock is the system clock.

Parameters:
- SCLK_DIV, 4: sclk half-period in clk cycles; legal range 2..255.
- DUMMY_CYCLES, 8: turnaround sclk periods between command byte and read data; legal range 0..15.
- GAP_CYCLES, 4: minimum cs-high time between frames, in clk cycles; must be ≥ 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_rw  in  1  1 = read, 0 = write
- req_addr  in  7  register address
- req_wdata  in  8  write data; ignored for reads
- rsp_valid  out  1  one-cycle pulse at frame completion
- rsp_rdata  out  8  read data; 0 for writes
- busy  out  1  frame in progress (state ≠ IDLE)
- sclk  out  1  SPI clock
- cs  out  1  SPI chip select, active low
- mosi  out  1  SPI data out
- miso  in  1  SPI data in

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: sclk=0, cs=1, mosi=0, rsp_valid=0, rsp_rdata=0, busy=0; state=IDLE.
- req_ready=1 exactly when state=IDLE (combinational); accept = req_valid & req_ready. The request is latched on accept.
- Command byte = {req_rw, req_addr}.
- Write frame: 16 bits, command then wdata.
- Read frame: 8 command bits, then DUMMY_CYCLES periods with mosi=0, then 8 data periods with mosi=0; miso captured MSB first.
- FSM states:
  - IDLE → SETUP on accept: cs drops the next cycle.
  - SETUP: SCLK_DIV cycles, sclk=0 → SHIFT.
  - SHIFT: each bit period = sclk high for SCLK_DIV cycles, then low for SCLK_DIV cycles. mosi changes only in the cycle sclk rises. miso is sampled in the cycle sclk falls, during the 8 data periods only. After the last falling edge → HOLD.
  - HOLD: SCLK_DIV cycles, sclk=0. Then cs=1, rsp_valid=1 for one cycle and rsp_rdata updated (read result, or 0 for a write), → GAP.
  - GAP: GAP_CYCLES cycles, cs=1 → IDLE.
- Latency, with accept at cycle T and D=SCLK_DIV: cs low at T+1; first sclk rise at T+1+D.
  - Write: cs high and rsp_valid at T+1+33D.
  - Read: cs high and rsp_valid at T+1+(2·(16+DUMMY_CYCLES)+1)·D; for the defaults this is T+197.
- Counters: half-period counter 8 bits; bit counter 5 bits, counting down from the total frame bit count. No wrap; the counter is reloaded at each state entry.
- req_valid while busy: ignored; inputs are not sampled, no queueing.
- rsp_rdata holds its value until the next completion.
- Reset mid-frame: cs=1 and sclk=0 immediately (asynchronous), no rsp_valid, state returns to IDLE. The aborted frame is not retried.
- Request fields changing after accept have no effect.

Optional Feature:
- Macro: SPI_MISO_SYNC_EN.
- Defined: miso passes through a 2-flop synchronizer and the capture point moves 2 clk cycles after the sclk falling edge. SCLK_DIV must be ≥ 3. Frame timing and rsp_valid timing are unchanged.
- Undefined: miso is sampled directly in the cycle sclk falls.

Decomposition:
- Shared include spi_reg_defs.vh holds:
  - FSM state encodings (IDLE, SETUP, SHIFT, HOLD, GAP)
  - command bit index RW_BIT=7
  - command and data widths (8)
  - read/write opcode values
  - the peripheral uses the same file.
- One sub-module, spi_sclk_gen: half-period counter, sclk toggle, single-cycle rise_stb/fall_stb outputs, run/stop input.

Test Plan:
- Write, addr=0x12, wdata=0xA5, D=4 → peripheral model captures 0x12 then 0xA5 on sclk falling edges; exactly 16 rising edges; rsp_valid at T+133 with rsp_rdata=0.
- Read, addr=0x05, model drives 0x3C after 8 dummy periods → mosi command 0x85, rsp_rdata=0x3C at T+197, 24 sclk periods.
- Back-to-back: req_valid held high with two requests → second accept no earlier than GAP_CYCLES after cs rises; req_ready=0 throughout the first frame.
- rst_n pulsed low at the 10th sclk rise → cs=1 and sclk=0 in the same cycle, no rsp_valid; a following write completes normally.
- SCLK_DIV=2, DUMMY_CYCLES=0, read 0x7F with model returning 0xFF → rdata=0xFF; sclk period exactly 4 clk cycles.
- With SPI_MISO_SYNC_EN, SCLK_DIV=3, read returning 0x81 → rdata=0x81 and identical frame timing.

Source files
------------

// File: rtl/spi_reg_master_pkg.sv
// Shared definitions for the SPI register master and its peripheral:
// FSM state encodings, command byte layout, widths and opcodes.
package spi_reg_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  localparam int RW_BIT = 7;
  localparam int CMD_W  = 8;
  localparam int DATA_W = 8;

  localparam logic OP_READ  = 1'b1;
  localparam logic OP_WRITE = 1'b0;

  function automatic logic [CMD_W-1:0] cmd_byte(input logic rw, input logic [RW_BIT-1:0] addr);
    return {rw, addr};
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI clock generator: half-period counter, registered sclk, strobes one cycle before each edge.
// Stopping (run=0) forces sclk low and clears the counter, so strobes stay quiet while stopped.
module spi_sclk_gen #(
  parameter int SCLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb
);

  logic [7:0] half_cnt;
  logic       tick;

  // Counter sits at 0 when stopped and SCLK_DIV >= 2, so tick cannot fire then.
  assign tick     = (half_cnt == 8'(SCLK_DIV - 1));
  assign rise_stb = tick & ~sclk;
  assign fall_stb = tick & sclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_cnt <= 8'd0;
      sclk     <= 1'b0;
    end else if (!run) begin
      half_cnt <= 8'd0;
      sclk     <= 1'b0;
    end else if (tick) begin
      half_cnt <= 8'd0;
      sclk     <= ~sclk;
    end else begin
      half_cnt <= half_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/spi_reg_master.sv
// SPI (CPOL=0, CPHA=1) single-register read/write initiator; one request at a time, req_ready only in IDLE.
// Optional SPI_MISO_SYNC_EN: miso through a 2-flop synchronizer, captured 2 clk after each sclk fall.
module spi_reg_master
  import spi_reg_master_pkg::*;
#(
  parameter int SCLK_DIV     = 4,
  parameter int DUMMY_CYCLES = 8,
  parameter int GAP_CYCLES   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_rw,
  input  logic [RW_BIT-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                busy,
  output logic                sclk,
  output logic                cs,
  output logic                mosi,
  input  logic                miso
);

  localparam logic [4:0] WR_BITS = 5'(CMD_W + DATA_W);
  localparam logic [4:0] RD_BITS = 5'(CMD_W + DATA_W + DUMMY_CYCLES);
  localparam int         GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t                    state;
  logic [CMD_W+DATA_W-1:0]   tx_sr;
  logic [DATA_W-1:0]         rx_sr;
  logic                      rd;
  logic [4:0]                bit_cnt;
  logic [GAP_W-1:0]          gap_cnt;
  logic                      run;
  logic                      rise_stb;
  logic                      fall_stb;
  logic                      accept;
  logic                      data_phase;
  logic                      cap_stb;
  logic                      cap_bit;

  assign req_ready = (state == ST_IDLE);
  assign busy      = ~req_ready;
  assign accept    = req_valid & req_ready;

  // The rise strobe that ends HOLD is the point where the generator must park low instead of rising.
  assign run = (state == ST_SETUP) | (state == ST_SHIFT) | ((state == ST_HOLD) & ~rise_stb);

  // Read data occupies the last 8 bit periods of a read frame.
  assign data_phase = rd & (state == ST_SHIFT) & (bit_cnt <= 5'(DATA_W));

  spi_sclk_gen #(.SCLK_DIV(SCLK_DIV)) u_sclk_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .sclk     (sclk),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

`ifdef SPI_MISO_SYNC_EN
  logic [1:0] miso_sync;
  logic [1:0] cap_dly;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_sync <= 2'b00;
      cap_dly   <= 2'b00;
    end else begin
      miso_sync <= {miso_sync[0], miso};
      cap_dly   <= {cap_dly[0], fall_stb & data_phase};
    end
  end

  assign cap_stb = cap_dly[1];
  assign cap_bit = miso_sync[1];
`else
  assign cap_stb = fall_stb & data_phase;
  assign cap_bit = miso;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sr <= '0;
    end else if (accept) begin
      rx_sr <= '0;
    end else if (cap_stb) begin
      rx_sr <= {rx_sr[DATA_W-2:0], cap_bit};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cs        <= 1'b1;
      mosi      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      tx_sr     <= '0;
      rd        <= 1'b0;
      bit_cnt   <= 5'd0;
      gap_cnt   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state <= ST_SETUP;
            cs    <= 1'b0;
            rd    <= (req_rw == OP_READ);
            tx_sr <= {cmd_byte(req_rw, req_addr), (req_rw == OP_READ) ? '0 : req_wdata};
          end
        end
        ST_SETUP: begin
          if (rise_stb) begin
            state   <= ST_SHIFT;
            mosi    <= tx_sr[CMD_W+DATA_W-1];
            tx_sr   <= {tx_sr[CMD_W+DATA_W-2:0], 1'b0};
            bit_cnt <= rd ? RD_BITS : WR_BITS;
          end
        end
        ST_SHIFT: begin
          // Zeros shift in behind the command, covering dummy and read-data periods.
          if (rise_stb) begin
            mosi  <= tx_sr[CMD_W+DATA_W-1];
            tx_sr <= {tx_sr[CMD_W+DATA_W-2:0], 1'b0};
          end else if (fall_stb) begin
            bit_cnt <= bit_cnt - 5'd1;
            if (bit_cnt == 5'd1) state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (rise_stb) begin
            state     <= ST_GAP;
            cs        <= 1'b1;
            mosi      <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= rd ? rx_sr : '0;
            gap_cnt   <= GAP_W'(GAP_CYCLES - 1);
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) state <= ST_IDLE;
          else gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
